// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for an output-stationary systolic array: clears the
// accumulators, streams k_len operand pairs, drains the pipeline, hands off.
module systolic_tile_sequencer #(
    parameter int ARRAY_COLS  = 8,
    parameter int MAC_LATENCY = 3,
    parameter int ADDR_WIDTH  = 10,
    parameter int K_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [K_WIDTH-1:0]    cfg_k_len,
    input  logic [ADDR_WIDTH-1:0] cfg_act_base,
    input  logic [ADDR_WIDTH-1:0] cfg_wgt_base,
    input  logic                  rd_stall,
    input  logic                  sa_valid_out,
    input  logic                  sa_overflow,
    input  logic                  res_ready,
    output logic                  sa_enable,
    output logic                  sa_clear_acc,
    output logic                  sa_valid_reset,
    output logic                  sa_data_valid_in,
    output logic                  feed_zero,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] act_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    output logic                  res_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ovf_sticky
);

    localparam int PRIME_CYCLES = 2 * ARRAY_COLS - 1 + MAC_LATENCY;
    localparam int DW = $clog2(PRIME_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PRIME_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [K_WIDTH-1:0]    k_len_q, k_len_d;
    logic [ADDR_WIDTH-1:0] act_base_q, act_base_d;
    logic [ADDR_WIDTH-1:0] wgt_base_q, wgt_base_d;
    logic [K_WIDTH-1:0]    step_q, step_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_len_q    <= '0;
            act_base_q <= '0;
            wgt_base_q <= '0;
            step_q     <= '0;
            drain_q    <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_len_q    <= k_len_d;
            act_base_q <= act_base_d;
            wgt_base_q <= wgt_base_d;
            step_q     <= step_d;
            drain_q    <= drain_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_len_d    = k_len_q;
        act_base_d = act_base_q;
        wgt_base_d = wgt_base_q;
        step_d     = step_q;
        drain_d    = drain_q;
        ovf_d      = ovf_q;
        err_d      = 1'b0;

        if (abort) begin
            // abort beats start, handshake and final-count events alike
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_k_len != '0) begin
                            k_len_d    = cfg_k_len;
                            act_base_d = cfg_act_base;
                            wgt_base_d = cfg_wgt_base;
                            state_d    = S_CLEAR;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    step_d  = '0;
                    drain_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_FEED;
                end
                S_FEED: begin
                    if (!rd_stall) begin
                        if (step_q == k_len_q - K_WIDTH'(1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            step_d = step_q + K_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!rd_stall) begin
                        if (drain_q == DRAIN_LAST) begin
                            if (sa_valid_out) begin
                                state_d = S_WRITE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            drain_d = drain_q + DW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (res_ready) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (sa_overflow && (state_q == S_FEED || state_q == S_DRAIN ||
                            state_q == S_WRITE)) begin
            ovf_d = 1'b1;
        end
    end

    // Only the enable and read strobe see rd_stall combinationally.
    assign sa_enable        = (state_q == S_FEED || state_q == S_DRAIN) && !rd_stall;
    assign rd_en            = (state_q == S_FEED) && !rd_stall;
    assign sa_clear_acc     = (state_q == S_CLEAR);
    assign sa_valid_reset   = (state_q == S_CLEAR);
    assign sa_data_valid_in = (state_q == S_FEED);
    assign feed_zero        = (state_q == S_DRAIN);
    assign act_addr         = act_base_q + ADDR_WIDTH'(step_q);
    assign wgt_addr         = wgt_base_q + ADDR_WIDTH'(step_q);
    assign res_valid        = (state_q == S_WRITE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign err              = err_q;
    assign ovf_sticky       = ovf_q;

endmodule
